// File: rtl/perf_pkg.sv
// Shared encodings for the pipeline performance monitor.
// Optional shadow-snapshot bank is enabled with `define PERF_SNAPSHOT_EN (see pipe_perf_monitor).
package perf_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int RD_SEL_W     = 4;
   localparam int RD_SEL_CYCLE = 0;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } perf_state_e;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky overflow flag; clear and reset both zero it.
// Shared by the cycle counter and every event counter of pipe_perf_monitor.
module perf_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   // An increment attempted at all-ones holds the value and flags overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_o <= '0;
         ovf_o <= 1'b0;
      end else if (inc_i) begin
         if (&cnt_o) ovf_o <= 1'b1;
         else        cnt_o <= cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle + event performance monitor with auto-stop at CYCLE_LIMIT and a registered read port.
// `define PERF_SNAPSHOT_EN adds snap_i and a shadow bank that the read port then serves.
module pipe_perf_monitor
   import perf_pkg::*;
#(
   parameter int NUM_EVENTS  = 4,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 30
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  clear_i,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic [RD_SEL_W-1:0]   rd_sel_i,
`ifdef PERF_SNAPSHOT_EN
   input  logic                  snap_i,
`endif
   output logic [CNT_W-1:0]      rd_data_o,
   output logic [NUM_EVENTS:0]   ovf_o,
   output logic                  running_o,
   output logic                  done_o
);

   // Stop decision compares the pre-increment cycle count against LIMIT-1.
   localparam logic [CNT_W-1:0] LIM_M1 = (CYCLE_LIMIT == 0) ? '0 : CNT_W'(CYCLE_LIMIT - 1);

   perf_state_e                    state, state_nx;
   logic                           count_en;
   logic                           lim_hit;
   logic [NUM_EVENTS:0]            inc;
   logic [NUM_EVENTS:0][CNT_W-1:0] cnt;
   logic [NUM_EVENTS:0][CNT_W-1:0] rd_src;
   logic [CNT_W-1:0]               rd_mux;

   assign count_en = (state == S_RUN) && start_i;
   assign lim_hit  = (CYCLE_LIMIT != 0) && count_en && (cnt[RD_SEL_CYCLE] == LIM_M1);
   assign inc      = {event_i & {NUM_EVENTS{count_en}}, count_en};

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (clear_i) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start_i) state_nx = S_RUN;
            S_RUN:   if (lim_hit) state_nx = S_DONE;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   assign running_o = (state == S_RUN);
   assign done_o    = (state == S_DONE);

   // Index 0 is the cycle counter, index k+1 tracks event_i[k].
   for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
      perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clear_i),
         .inc_i (inc[g]),
         .cnt_o (cnt[g]),
         .ovf_o (ovf_o[g])
      );
   end

`ifdef PERF_SNAPSHOT_EN
   logic [NUM_EVENTS:0][CNT_W-1:0] shadow;

   // Shadow survives clear_i so a snapshot can be read after the live bank is wiped.
   always_ff @(posedge clk_i) begin
      if (rst_i)       shadow <= '0;
      else if (snap_i) shadow <= cnt;
   end

   assign rd_src = shadow;
`else
   assign rd_src = cnt;
`endif

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i <= NUM_EVENTS; i++)
         if (rd_sel_i == RD_SEL_W'(RD_SEL_CYCLE + i)) rd_mux = rd_src[i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rd_data_o <= '0;
      else       rd_data_o <= rd_mux;
   end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench for pipe_perf_monitor: stimulus queues expectations, a negedge monitor checks them.
// Instance a uses default parameters, instance b uses CNT_W=4 / CYCLE_LIMIT=0 for saturation.
module tb_pipe_perf_monitor;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      start, clear;
   logic [1:0][3:0] ev, sel;
`ifdef PERF_SNAPSHOT_EN
   logic [1:0]      snap;
`endif
   logic [31:0]     rd_a;
   logic [3:0]      rd_b;
   logic [4:0]      ovf_a, ovf_b;
   logic            run_a, run_b, done_a, done_b;

   always #5 clk = ~clk;

   pipe_perf_monitor #(.NUM_EVENTS(4), .CNT_W(32), .CYCLE_LIMIT(30)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .clear_i(clear[0]),
      .event_i(ev[0]), .rd_sel_i(sel[0]),
`ifdef PERF_SNAPSHOT_EN
      .snap_i(snap[0]),
`endif
      .rd_data_o(rd_a), .ovf_o(ovf_a), .running_o(run_a), .done_o(done_a));

   pipe_perf_monitor #(.NUM_EVENTS(4), .CNT_W(4), .CYCLE_LIMIT(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .clear_i(clear[1]),
      .event_i(ev[1]), .rd_sel_i(sel[1]),
`ifdef PERF_SNAPSHOT_EN
      .snap_i(snap[1]),
`endif
      .rd_data_o(rd_b), .ovf_o(ovf_b), .running_o(run_b), .done_o(done_b));

   // kind: 0 rd_data, 1 ovf, 2 running, 3 done
   typedef struct packed {
      int          due;
      int          dut;
      int          kind;
      logic [31:0] exp;
   } chk_t;

   chk_t  q[$];
   string nq[$];
   int    edge_cnt = 0;
   int    total = 0;
   int    bad = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [31:0] actual(input chk_t c);
      case (c.kind)
         0:       return (c.dut == 0) ? rd_a : {28'b0, rd_b};
         1:       return (c.dut == 0) ? {27'b0, ovf_a} : {27'b0, ovf_b};
         2:       return {31'b0, (c.dut == 0) ? run_a : run_b};
         default: return {31'b0, (c.dut == 0) ? done_a : done_b};
      endcase
   endfunction

   chk_t        mc;
   string       mn;
   logic [31:0] ma;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
         mc = q.pop_front();
         mn = nq.pop_front();
         ma = actual(mc);
         total++;
         if (mc.due != edge_cnt || ma !== mc.exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (due %0d at %0d)", mn, ma, mc.exp, mc.due, edge_cnt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expectation on the DUT outputs as they stand after the next clock edge.
   task automatic expect_nx(input int d, input int k, input int s, input logic [31:0] e, input string n);
      chk_t c;
      c.due  = edge_cnt + 1;
      c.dut  = d;
      c.kind = k;
      c.exp  = e;
      q.push_back(c);
      nq.push_back(n);
      if (k == 0) sel[d] = 4'(s);
   endtask

   task automatic rd(input int d, input int s, input logic [31:0] e, input string n);
`ifdef PERF_SNAPSHOT_EN
      snap[d] = 1'b1;
      tick();
      snap[d] = 1'b0;
`endif
      expect_nx(d, 0, s, e, n);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit hit, got no summary want summary");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = '0; clear = '0; ev = '0; sel = '0;
`ifdef PERF_SNAPSHOT_EN
      snap = '0;
`endif
      // Reset state
      expect_nx(0, 0, 0, 0, "rst_rd");
      expect_nx(0, 1, 0, 0, "rst_ovf");
      expect_nx(0, 2, 0, 0, "rst_run");
      expect_nx(0, 3, 0, 0, "rst_done");
      expect_nx(1, 1, 0, 0, "rst_ovf_b");
      tick(); tick();
      rst = 1'b0;

      // 1: auto-stop after 30 counting edges
      start[0] = 1'b1;
      tick();
      for (int i = 1; i <= 30; i++) begin
         if (i == 29) expect_nx(0, 3, 0, 0, "t1_done_early");
         if (i == 30) begin
            expect_nx(0, 3, 0, 1, "t1_done");
            expect_nx(0, 2, 0, 0, "t1_run_off");
         end
         tick();
      end
      repeat (3) tick();
      rd(0, 0, 30, "t1_cycle");
      rd(0, 1, 0, "t1_ev0");
      rd(0, 4, 0, "t1_ev3");
      expect_nx(0, 3, 0, 1, "t1_done_hold");
      tick();

      // 2: toggled and constant events
      start[0] = 1'b0; clear[0] = 1'b1;
      expect_nx(0, 3, 0, 0, "t2_clr_done");
      tick();
      clear[0] = 1'b0; start[0] = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         ev[0] = (i % 2 == 0) ? 4'b0011 : 4'b0010;
         tick();
      end
      start[0] = 1'b0; ev[0] = '0;
      rd(0, 0, 10, "t2_cycle");
      rd(0, 1, 5, "t2_ev0");
      rd(0, 2, 10, "t2_ev1");
      rd(0, 3, 0, "t2_ev2");
      rd(0, 5, 0, "t2_sel_oob5");
      rd(0, 15, 0, "t2_sel_oob15");
      expect_nx(0, 2, 0, 1, "t2_run_paused");
      tick();

      // 4: pause window keeps RUN and counts nothing
      clear[0] = 1'b1; tick(); clear[0] = 1'b0;
      start[0] = 1'b1; tick();
      repeat (5) tick();
      start[0] = 1'b0; ev[0] = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         expect_nx(0, 2, 0, 1, "t4_run_low");
         tick();
      end
      ev[0] = '0; start[0] = 1'b1;
      repeat (4) tick();
      start[0] = 1'b0;
      rd(0, 0, 9, "t4_cycle");
      rd(0, 3, 0, "t4_ev2");
      expect_nx(0, 3, 0, 0, "t4_done");
      tick();

      // 5: clear beats events, restart one edge later
      clear[0] = 1'b1; tick(); clear[0] = 1'b0;
      start[0] = 1'b1; tick();
      ev[0] = 4'hF;
      repeat (3) tick();
      clear[0] = 1'b1;
      expect_nx(0, 2, 0, 0, "t5_clr_idle");
      expect_nx(0, 1, 0, 0, "t5_clr_ovf");
      tick();
      clear[0] = 1'b0;
      expect_nx(0, 2, 0, 1, "t5_reenter");
      tick();
      tick();
      start[0] = 1'b0; ev[0] = '0;
      rd(0, 0, 1, "t5_cycle");
      rd(0, 1, 1, "t5_ev0");
      rd(0, 4, 1, "t5_ev3");

      // 3: saturation on the narrow instance
      start[1] = 1'b1;
      tick();
      ev[1] = 4'b0100;
      for (int i = 1; i <= 20; i++) begin
         if (i == 15) expect_nx(1, 1, 0, 0, "t3_ovf_pre");
         if (i == 16) expect_nx(1, 1, 0, 5'b01001, "t3_ovf");
         tick();
      end
      start[1] = 1'b0; ev[1] = '0;
      rd(1, 0, 15, "t3_cycle");
      rd(1, 3, 15, "t3_ev2");
      rd(1, 1, 0, "t3_ev0");
      expect_nx(1, 1, 0, 5'b01001, "t3_ovf_hold");
      expect_nx(1, 2, 0, 1, "t3_run");
      expect_nx(1, 3, 0, 0, "t3_done");
      tick();
      clear[1] = 1'b1;
      expect_nx(1, 1, 0, 0, "t3_clr_ovf");
      tick();
      clear[1] = 1'b0;
      rd(1, 3, 0, "t3_clr_ev2");

`ifdef PERF_SNAPSHOT_EN
      // 6: snapshot keeps pre-increment value across clear
      clear[0] = 1'b1; tick(); clear[0] = 1'b0;
      start[0] = 1'b1; tick();
      for (int i = 1; i <= 12; i++) begin
         snap[0] = (i == 7);
         tick();
      end
      snap[0] = 1'b0; start[0] = 1'b0;
      expect_nx(0, 0, 0, 6, "t6_snap");
      tick();
      clear[0] = 1'b1; tick(); clear[0] = 1'b0;
      expect_nx(0, 0, 0, 6, "t6_snap_clr");
      tick();
`endif

      repeat (2) tick();
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
